// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sad_pkg
//  Brief    : Shared defaults and width/slice helpers for the SAD accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
package sad_pkg;

    localparam int PIX_W_DEF = 8;

    // Output width that holds LANES*BEATS maximal differences without overflow.
    function automatic int sum_width(input int pix_w, input int lanes, input int beats);
        return pix_w + $clog2(lanes * beats);
    endfunction

    function automatic int lane_lo(input int lane, input int pix_w);
        return lane * pix_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sad_absdiff_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sad_absdiff_lane
//  Brief    : One lane of S1 (signed difference) and S2 (|diff| via XOR + carry).
//  Revision : 1.0 - initial release
// ============================================================================
module sad_absdiff_lane #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             adv,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] abs_val
);

    logic [PIX_W:0]   d_q;
    logic             sign;
    logic [PIX_W-1:0] mag;

    // Conditional invert plus carry-in; the sign bit is dropped since |a-b| fits PIX_W.
    always_comb begin
        sign = d_q[PIX_W];
        mag  = (d_q[PIX_W-1:0] ^ {PIX_W{sign}}) + PIX_W'(sign);
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            d_q     <= {1'b0, a} - {1'b0, b};
            abs_val <= mag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sad_absdiff_acc.sv
`default_nettype none
// ============================================================================
//  Module   : sad_absdiff_acc
//  Brief    : Pipelined multi-lane |a-b| accumulator producing one SAD per block.
//             Optional running-minimum tracker enabled by SAD_MIN_TRACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module sad_absdiff_acc
    import sad_pkg::*;
#(
    parameter  int PIX_W = PIX_W_DEF,
    parameter  int LANES = 4,
    parameter  int BEATS = 16,
    localparam int SUM_W = sum_width(PIX_W, LANES, BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] in_a,
    input  logic [LANES*PIX_W-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_W-1:0]       out_sad,
    output logic                   busy
`ifdef SAD_MIN_TRACK_EN
    ,
    input  logic                   min_clr,
    output logic [SUM_W-1:0]       min_sad,
    output logic [15:0]            min_idx
`endif
);

    localparam int TREE_W = PIX_W + $clog2(LANES);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic              adv;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              s1_valid, s1_last;
    logic              s2_valid, s2_last;
    logic              s3_valid, s3_last;
    logic [PIX_W-1:0]  abs_val [LANES];
    logic [TREE_W-1:0] tree_sum;
    logic [TREE_W-1:0] s3_sum;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  blk_sum;
    logic              emit;

    // The whole pipeline freezes only when a finished SAD is blocked downstream.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign cnt_last = (cnt == CNT_W'(BEATS - 1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sad_absdiff_lane #(
            .PIX_W (PIX_W)
        ) u_lane (
            .clk     (clk),
            .adv     (adv),
            .a       (in_a[lane_lo(i, PIX_W) +: PIX_W]),
            .b       (in_b[lane_lo(i, PIX_W) +: PIX_W]),
            .abs_val (abs_val[i])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + TREE_W'(abs_val[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
        end else if (adv) begin
            if (in_valid) begin
                cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
            s1_valid <= in_valid;
            s1_last  <= in_valid && cnt_last;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s3_sum <= tree_sum;
        end
    end

    assign blk_sum = acc + SUM_W'(s3_sum);
    assign emit    = adv && s3_valid && s3_last;

    // A new result may land in the same cycle the previous one is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_sad   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (emit) begin
                out_sad   <= blk_sum;
                out_valid <= 1'b1;
                acc       <= '0;
            end else begin
                if (adv && s3_valid) begin
                    acc <= blk_sum;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign busy = s1_valid || s2_valid || s3_valid || out_valid || (cnt != '0);

`ifdef SAD_MIN_TRACK_EN
    logic [15:0] blk_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            min_sad <= '1;
            min_idx <= '0;
            blk_idx <= '0;
        end else if (min_clr) begin
            min_sad <= emit ? blk_sum : '1;
            min_idx <= '0;
            blk_idx <= emit ? 16'd1 : 16'd0;
        end else if (emit) begin
            if (blk_sum < min_sad) begin
                min_sad <= blk_sum;
                min_idx <= blk_idx;
            end
            blk_idx <= blk_idx + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sad_absdiff_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sad_absdiff_acc
//  Brief    : Directed self-checking bench for sad_absdiff_acc (8-bit, 4 lanes, 4 beats).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sad_absdiff_acc;

    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int BEATS = 4;
    localparam int SUM_W = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] in_a;
    logic [LANES*PIX_W-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [SUM_W-1:0]       out_sad;
    logic                   busy;
`ifdef SAD_MIN_TRACK_EN
    logic                   min_clr;
    logic [SUM_W-1:0]       min_sad;
    logic [15:0]            min_idx;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [SUM_W-1:0] sad_q [$];
    int               cyc_q [$];
    int st_a, st_b, c1, c2;

    sad_absdiff_acc #(
        .PIX_W (PIX_W),
        .LANES (LANES),
        .BEATS (BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sad   (out_sad),
        .busy      (busy)
`ifdef SAD_MIN_TRACK_EN
        ,
        .min_clr   (min_clr),
        .min_sad   (min_sad),
        .min_idx   (min_idx)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted result; inputs only change 1 time unit after posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            sad_q.push_back(out_sad);
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, inout int stalls);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $error("FAIL beat_accept: observed=no in_ready expected=in_ready within 100 cycles");
        end
        stalls += w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_uniform(input logic [7:0] a, input logic [7:0] b, inout int stalls);
        for (int k = 0; k < BEATS; k++) begin
            send_beat({4{a}}, {4{b}}, stalls);
        end
    endtask

    // Lane 0 carries diff d on the first three beats and e on the last; other lanes zero.
    task automatic send_lane0(input logic [7:0] d, input logic [7:0] e, inout int stalls);
        for (int k = 0; k < BEATS; k++) begin
            send_beat(32'd0, {24'd0, (k == BEATS - 1) ? e : d}, stalls);
        end
    endtask

    task automatic expect_next(input string tag, input logic [31:0] exp, output int at_cyc);
        int n;
        n      = 0;
        at_cyc = -1;
        while (sad_q.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        if (sad_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=no result expected=%0d", tag, exp);
        end else begin
            at_cyc = cyc_q.pop_front();
            check(tag, 32'(sad_q.pop_front()), exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
`ifdef SAD_MIN_TRACK_EN
        min_clr   = 1'b0;
`endif
        st_a = 0;
        st_b = 0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sad", 32'(out_sad), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Maximum difference on every lane, plus exact latency.
        send_uniform(8'hFF, 8'h00, st_a);
        check("lat_e0", 32'(out_valid), 32'd0);
        check("busy_in_flight", 32'(busy), 32'd1);
        tick();
        check("lat_e1", 32'(out_valid), 32'd0);
        tick();
        check("lat_e2", 32'(out_valid), 32'd0);
        tick();
        check("lat_e3", 32'(out_valid), 32'd1);
        check("max_sad_direct", 32'(out_sad), 32'd4080);
        expect_next("max_sad", 32'd4080, c1);

        // Negative differences.
        send_uniform(8'h10, 8'h30, st_a);
        expect_next("neg_sad", 32'd512, c1);

        // Back-to-back blocks at full rate.
        st_a = 0;
        send_uniform(8'h05, 8'h04, st_a);
        send_uniform(8'h06, 8'h08, st_a);
        check("b2b_no_stall", 32'(st_a), 32'd0);
        expect_next("b2b_first", 32'd16, c1);
        expect_next("b2b_second", 32'd32, c2);
        check("b2b_spacing", 32'(c2 - c1), 32'd4);

        // Downstream stall while the next block streams in.
        repeat (4) tick();
        out_ready = 1'b0;
        st_a = 0;
        st_b = 0;
        send_uniform(8'h05, 8'h00, st_a);
        fork
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        send_uniform(8'h00, 8'h07, st_b);
        check("stall_first_free", 32'(st_a), 32'd0);
        check("stall_in_ready_dropped", 32'(st_b > 0), 32'd1);
        expect_next("stall_first", 32'd80, c1);
        expect_next("stall_second", 32'd112, c2);

        // Reset in the middle of a block.
        repeat (4) tick();
        send_beat({4{8'd9}}, 32'd0, st_a);
        send_beat({4{8'd9}}, 32'd0, st_a);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send_uniform(8'h03, 8'h00, st_a);
        expect_next("midrst_sad", 32'd48, c1);
        repeat (6) tick();
        check("no_residue", 32'(sad_q.size()), 32'd0);

`ifdef SAD_MIN_TRACK_EN
        min_clr = 1'b1;
        tick();
        min_clr = 1'b0;
        check("minclr0_sad", 32'(min_sad), 32'hFFF);
        send_lane0(8'd25, 8'd25, st_a);
        send_lane0(8'd10, 8'd10, st_a);
        send_lane0(8'd10, 8'd10, st_a);
        send_lane0(8'd20, 8'd10, st_a);
        expect_next("min_blk0", 32'd100, c1);
        expect_next("min_blk1", 32'd40, c1);
        expect_next("min_blk2", 32'd40, c1);
        expect_next("min_blk3", 32'd70, c1);
        tick();
        check("min_sad", 32'(min_sad), 32'd40);
        check("min_idx", 32'(min_idx), 32'd1);
        min_clr = 1'b1;
        tick();
        min_clr = 1'b0;
        check("minclr_sad", 32'(min_sad), 32'hFFF);
        check("minclr_idx", 32'(min_idx), 32'd0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sad_absdiff_acc.md
Name: sad_absdiff_acc

Overview:
- Parametrised, pipelined absolute-difference accumulator for the full-search SAD engine; next generation of the 32-bit bitwise XOR stage.
- Takes LANES pixel pairs per beat and forms |a−b| per lane with an XOR conditional-invert plus carry-in. It reduces the lanes with an adder tree and accumulates BEATS beats into one candidate-block SAD.
- Sits between the reference/candidate pixel fetch and the motion-vector compare logic; valid/ready on both sides.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- LANES, 4, pixel pairs per input beat; power of 2, ≥1.
- BEATS, 16, beats per candidate block; ≥1.
- SUM_W (localparam), PIX_W + $clog2(LANES*BEATS), output width; never overflows.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_a  in  LANES*PIX_W  current pixels, lane i = [i*PIX_W +: PIX_W].
- in_b  in  LANES*PIX_W  candidate pixels, same packing.
- out_valid  out  1  block SAD valid.
- out_ready  in  1  downstream accepts SAD.
- out_sad  out  SUM_W  SAD of the completed block.
- busy  out  1  any stage, accumulator or output holds data.

Behaviour:
- One clock; reset is synchronous and active-high. On rst, all of the following clear to 0: stage valids, beat counter, accumulator, out_valid, out_sad. busy is 0 and in_ready is 1 the cycle after rst deasserts.
- Global advance: adv = !(out_valid && !out_ready). in_ready = adv. When adv=0, every pipeline register, the counter and the accumulator hold.
- S1: register d_i = {1'b0,a_i} − {1'b0,b_i} (PIX_W+1 bits), plus a last flag. The last flag is set when beat count == BEATS−1; the counter then wraps to 0.
- S2: abs_i = (d_i[PIX_W:0] ^ {PIX_W+1{s_i}}) + s_i, where s_i = d_i[PIX_W]. Result truncated to PIX_W bits; |a−b| ≤ 2^PIX_W−1 is exact.
- S3: adder tree across lanes, width PIX_W+$clog2(LANES), registered with valid and last.
- Accumulate: when S3 is valid and adv:
  - not last: acc += tree.
  - last: out_sad <= acc + tree, out_valid <= 1, acc <= 0 in the same cycle.
- Latency: the last beat accepted at cycle t gives out_valid at t+3 with no stall. Back-to-back blocks run at full throughput, one beat per cycle.
- Output handshake: out_valid and out_sad stay stable until out_ready. out_valid clears on handshake unless a new result lands in the same cycle; in that case it stays 1 with the new value.
- Bubbles (in_valid=0) propagate as invalid stages and do not touch acc or the counter.
- BEATS=1: every beat is last. LANES=1: the adder tree is a wire-through register.
- Reset mid-block discards the partial sum and restarts the beat count at 0.

Optional Feature:
- Macro SAD_MIN_TRACK_EN.
- Defined:
  - Adds ports min_clr (in, 1), min_sad (out, SUM_W), min_idx (out, 16).
  - Each emitted SAD gets a block index counting 0,1,2… from rst or min_clr.
  - min_sad/min_idx update when SAD < min_sad; ties keep the earlier index.
  - min_clr sets min_sad to all-ones and the index counter to 0. If min_clr coincides with an emission, the emitted block becomes index 0 and the new min.
  - Reset values: min_sad all-ones, min_idx 0.
- Undefined: these ports and that logic are absent; core behaviour is identical.

Decomposition:
- Package sad_pkg: PIX_W default, a clog2-based SUM_W helper function, and a lane-slice helper.
- One natural sub-module: sad_absdiff_lane (one lane of S1/S2, conditional XOR-invert), instantiated LANES times by generate. The tree and accumulator stay in the top level.

Test Plan (PIX_W=8, LANES=4, BEATS=4):
- All lanes a=0xFF, b=0x00, 4 consecutive beats, out_ready=1 -> out_sad=4080 (0xFF0), out_valid exactly 3 cycles after the 4th beat.
- a=0x10, b=0x30 on all lanes (negative diff) -> 4*4*0x20 = 512.
- Two back-to-back blocks (first all diff 1, second all diff 2) -> 16 then 32 on consecutive out_valid, no gap in in_ready.
- Hold out_ready=0 for 5 cycles while a second block streams -> in_ready drops, nothing lost, both results correct in order.
- Assert rst after 2 beats of a block, then send a fresh block of diff 3 -> out_sad=48, no residue.
- With SAD_MIN_TRACK_EN: SADs 100, 40, 40, 70 -> min_sad=40, min_idx=1; pulse min_clr -> min_sad=0xFFF, min_idx=0.
